unsigned_mul_8x8_ha_array_accum: RTL
====================================

Name: unsigned_mul_8x8_ha_array_accum

Overview:
Downstream stage of the 8x8 approximate unsigned multiplier's half-adder-array stage. It accepts the four reduced partial-product rows (ha_array_k_t / ha_array_k_b, k = 0..3), weights and sums them in a 3-stage valid/ready pipeline, and produces the final 16-bit product. Results that exceed 16 bits are saturated, flagged, and counted. It sits between the ha_array stage and the multiplier's result consumer.

Parameters:
SAT_CNT_W, 8, width of the saturation-event counter (saturating, not wrapping)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  row bundle valid
in_ready  output  1  stage can accept a bundle this cycle
ha_array_0_t  input  9  row 0 top bits
ha_array_0_b  input  7  row 0 bottom bits
ha_array_1_t  input  9  row 1 top bits
ha_array_1_b  input  7  row 1 bottom bits
ha_array_2_t  input  9  row 2 top bits
ha_array_2_b  input  7  row 2 bottom bits
ha_array_3_t  input  9  row 3 top bits
ha_array_3_b  input  7  row 3 bottom bits
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  16  saturated product
ovf  output  1  product was saturated (qualified by out_valid)
sat_clr  input  1  synchronous clear of sat_count
sat_count  output  SAT_CNT_W  number of saturated results delivered

Behaviour:
- Weights: in row k, t[j] has weight 2^(2k+j) and b[j] has weight 2^(2k+j+2).
- Row value r_k = t_k + (b_k << 2), 10 bits unsigned (max 1019).
- Stage 1 (S1): on accept (in_valid & in_ready), register r0..r3.
- Stage 2 (S2): p01 = r0 + (r1 << 2); p23 = r2 + (r3 << 2). Both 13 bits, max 5095.
- Stage 3 (S3): sum = p01 + (p23 << 4), 17 bits, max 86615.
  - If sum[16] = 1: product = 16'hFFFF and ovf = 1.
  - Else: product = sum[15:0] and ovf = 0.
- Latency: 3 cycles from accept to out_valid with no backpressure. Throughput: 1 bundle per cycle.
- Handshake and flow control:
  - Each stage holds a valid bit. A stage advances when the next stage is empty or advancing; S3 advances when out_valid & out_ready.
  - in_ready = !S1_valid | S1_advance. A combinational path from out_ready to in_ready is permitted.
  - While out_valid & !out_ready, product and ovf stay stable. No bundle is dropped, duplicated, or reordered.
  - Inputs are sampled only on accept; rows are ignored when in_valid = 0.
- sat_count:
  - Increments by 1 on each output handshake with ovf = 1.
  - Holds at all-ones; it does not wrap.
  - sat_clr zeroes it. If sat_clr and a saturating handshake occur in the same cycle, sat_clr wins and the result is 0.
- Reset (asynchronous, any time, including mid-stream):
  - All stage valid bits = 0, out_valid = 0, product = 0, ovf = 0, sat_count = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - In-flight bundles are discarded.

Test Plan:
- Reset, then one bundle with all rows 0 -> out_valid exactly 3 cycles after accept; product = 0, ovf = 0.
- Row 0 t = 9'h001, all other bits 0 -> product = 1. Row 1 t = 9'h1FF -> product = 2044. Row 3 b = 7'h40 only -> product = 16384.
- All t and b bits 1 on every row -> sum = 86615, so product = 16'hFFFF and ovf = 1; sat_count goes 0 -> 1. Repeat 300 times -> sat_count = 255 (held). Pulse sat_clr -> 0.
- Stream 5 bundles back-to-back (products 1, 2, 4, 2044, 16384) with out_ready held low for 6 cycles:
  - in_ready falls after 3 accepts;
  - product stays stable while stalled;
  - after release, outputs appear in order with no loss or duplication.
- Random out_ready (50%) with 1000 random in-range bundles -> every output matches the reference model (weighted sum, then saturation), in order.
- Assert rst_n low while 3 bundles are in flight -> out_valid = 0 immediately; no stale result appears after reset deasserts; the next bundle completes with correct latency.

Source files
------------

// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Final accumulation stage of the 8x8 approximate unsigned multiplier.
// Weights the four reduced partial-product rows from the half-adder array and
// sums them over a 3-stage valid/ready pipeline. Sums that need a 17th bit
// saturate to 16'hFFFF, raise ovf, and are counted in sat_count.
module unsigned_mul_8x8_ha_array_accum #(
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8:0]           ha_array_0_t,
    input  logic [6:0]           ha_array_0_b,
    input  logic [8:0]           ha_array_1_t,
    input  logic [6:0]           ha_array_1_b,
    input  logic [8:0]           ha_array_2_t,
    input  logic [6:0]           ha_array_2_b,
    input  logic [8:0]           ha_array_3_t,
    input  logic [6:0]           ha_array_3_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          product,
    output logic                 ovf,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_count
);

    // Row inputs gathered into arrays so the per-row logic can be generated.
    logic [8:0] row_t   [4];
    logic [6:0] row_b   [4];
    logic [9:0] row_val [4];

    assign row_t[0] = ha_array_0_t;
    assign row_t[1] = ha_array_1_t;
    assign row_t[2] = ha_array_2_t;
    assign row_t[3] = ha_array_3_t;
    assign row_b[0] = ha_array_0_b;
    assign row_b[1] = ha_array_1_b;
    assign row_b[2] = ha_array_2_b;
    assign row_b[3] = ha_array_3_b;

    // Pipeline state.
    logic                 s1_valid_reg;
    logic [9:0]           s1_row_reg [4];
    logic                 s2_valid_reg;
    logic [12:0]          p01_reg;
    logic [12:0]          p23_reg;
    logic                 s3_valid_reg;
    logic [15:0]          product_reg;
    logic                 ovf_reg;
    logic [SAT_CNT_W-1:0] sat_count_reg;

    // Flow control: a stage moves forward when the next one is empty or moving.
    logic        s1_adv;
    logic        s2_adv;
    logic        s3_adv;
    logic        in_accept;
    logic [12:0] p01_next;
    logic [12:0] p23_next;
    logic [16:0] sum_next;

    assign s3_adv    = s3_valid_reg & out_ready;
    assign s2_adv    = s2_valid_reg & (~s3_valid_reg | s3_adv);
    assign s1_adv    = s1_valid_reg & (~s2_valid_reg | s2_adv);
    assign in_ready  = ~s1_valid_reg | s1_adv;
    assign in_accept = in_valid & in_ready;

    // Row k value: t bits at offset 0, b bits two places higher (row base 2^(2k) applied later).
    // Row pairs combine with a 2-bit shift; the two pair sums then combine with a 4-bit shift.
    assign p01_next = 13'(s1_row_reg[0]) + 13'({s1_row_reg[1], 2'b00});
    assign p23_next = 13'(s1_row_reg[2]) + 13'({s1_row_reg[3], 2'b00});
    assign sum_next = 17'(p01_reg) + 17'({p23_reg, 4'b0000});

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign row_val[gi] = 10'(row_t[gi]) + {1'b0, row_b[gi], 2'b00};

            // Stage 1 row register: captures this row's value only on accept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_row_reg[gi] <= '0;
                end else if (in_accept) begin
                    s1_row_reg[gi] <= row_val[gi];
                end
            end
        end
    endgenerate

    // Stage 1 occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (in_accept) begin
            s1_valid_reg <= 1'b1;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 2: pairwise row sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            p01_reg      <= '0;
            p23_reg      <= '0;
        end else if (s1_adv) begin
            s2_valid_reg <= 1'b1;
            p01_reg      <= p01_next;
            p23_reg      <= p23_next;
        end else if (s2_adv) begin
            s2_valid_reg <= 1'b0;
        end
    end

    // Stage 3: final sum with saturation; outputs hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_reg <= 1'b0;
            product_reg  <= '0;
            ovf_reg      <= 1'b0;
        end else if (s2_adv) begin
            s3_valid_reg <= 1'b1;
            product_reg  <= sum_next[16] ? 16'hFFFF : sum_next[15:0];
            ovf_reg      <= sum_next[16];
        end else if (s3_adv) begin
            s3_valid_reg <= 1'b0;
        end
    end

    // Saturation-event counter: sticks at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_reg <= '0;
        end else if (sat_clr) begin
            sat_count_reg <= '0;
        end else if (s3_adv && ovf_reg && (sat_count_reg != {SAT_CNT_W{1'b1}})) begin
            sat_count_reg <= sat_count_reg + SAT_CNT_W'(1);
        end
    end

    assign out_valid = s3_valid_reg;
    assign product   = product_reg;
    assign ovf       = ovf_reg;
    assign sat_count = sat_count_reg;

endmodule
